inst_prefetch_unit: RTL and testbench

Parametrised instruction-fetch front end. It replaces the fixed single-cycle instruction SRAM port with a request/grant/response memory interface that tolerates variable latency and several outstanding requests. Fetched words go into a DEPTH-entry queue and are handed to decode with a valid/ready handshake. A branch/jump redirect from decode flushes the queue and silently discards in-flight responses.

---
 rtl/inst_prefetch_unit.sv | 151 +++++++++++++++
 tb/tb_inst_prefetch_unit.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_prefetch_unit.sv
// Instruction prefetch front end: request/grant/response fetch into a DEPTH-entry queue, valid/ready to decode.
// Response-to-output latency 1 cycle (no bypass); queue slots reserved at grant so memory never sees backpressure.
module inst_prefetch_unit #(
    parameter int                 ADDR_W          = 32,
    parameter int                 DATA_W          = 32,
    parameter int                 DEPTH           = 4,
    parameter int                 MAX_OUTSTANDING = 2,
    parameter logic [ADDR_W-1:0]  RESET_PC        = ADDR_W'(32'h8000_0000)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              redirect_valid_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [ADDR_W-1:0] out_pc_o,
    output logic [DATA_W-1:0] out_inst_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              protocol_err_o
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int SW = CW + 1;
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_rsp_pc;
    logic [OW-1:0]     r_outstanding;
    logic [OW-1:0]     r_discard;
    logic [CW-1:0]     r_count;
    logic [PW-1:0]     r_rd_ptr;
    logic [PW-1:0]     r_wr_ptr;
    logic              r_protocol_err;
    logic [ADDR_W-1:0] r_q_pc   [DEPTH];
    logic [DATA_W-1:0] r_q_inst [DEPTH];

    logic              w_req;
    logic              w_grant;
    logic              w_rsp;
    logic              w_spurious;
    logic              w_push;
    logic              w_pop;
    logic [SW-1:0]     w_reserved;
    logic [OW-1:0]     w_outstanding_nxt;
    logic [OW-1:0]     w_discard_nxt;
    logic [CW-1:0]     w_count_nxt;

    // Live in-flight responses (outstanding minus those already doomed) each own a queue slot.
    assign w_reserved = SW'(r_count) + SW'(r_outstanding) - SW'(r_discard);
    assign w_req      = ~redirect_valid_i
                      & (r_outstanding < OW'(MAX_OUTSTANDING))
                      & (w_reserved < SW'(DEPTH));

    assign mem_req_o   = resetn & w_req;
    assign mem_addr_o  = r_fetch_pc;
    assign w_grant     = mem_req_o & mem_gnt_i;
    assign w_rsp       = mem_rvalid_i & (r_outstanding != '0);
    assign w_spurious  = mem_rvalid_i & (r_outstanding == '0);
    assign w_push      = w_rsp & ~redirect_valid_i & (r_discard == '0);

    assign out_valid_o    = (r_count != '0) & ~redirect_valid_i;
    assign w_pop          = out_valid_o & out_ready_i;
    assign out_pc_o       = r_q_pc[r_rd_ptr];
    assign out_inst_o     = r_q_inst[r_rd_ptr];
    assign protocol_err_o = r_protocol_err;

    always_comb begin
        w_outstanding_nxt = r_outstanding;
        if (w_grant) begin
            w_outstanding_nxt = w_outstanding_nxt + OW'(1);
        end
        if (w_rsp) begin
            w_outstanding_nxt = w_outstanding_nxt - OW'(1);
        end
    end

    // On redirect everything still in flight is stale; a response this cycle is already counted out.
    always_comb begin
        w_discard_nxt = r_discard;
        if (redirect_valid_i) begin
            w_discard_nxt = w_outstanding_nxt;
        end else if (w_rsp && (r_discard != '0)) begin
            w_discard_nxt = r_discard - OW'(1);
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        if (redirect_valid_i) begin
            w_count_nxt = '0;
        end else begin
            if (w_push && !w_pop) begin
                w_count_nxt = r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                w_count_nxt = r_count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_fetch_pc     <= RESET_PC;
            r_rsp_pc       <= RESET_PC;
            r_outstanding  <= '0;
            r_discard      <= '0;
            r_count        <= '0;
            r_rd_ptr       <= '0;
            r_wr_ptr       <= '0;
            r_protocol_err <= 1'b0;
        end else begin
            if (redirect_valid_i) begin
                r_fetch_pc <= redirect_pc_i;
                r_rsp_pc   <= redirect_pc_i;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
            end else begin
                if (w_grant) begin
                    r_fetch_pc <= r_fetch_pc + PC_STEP;
                end
                if (w_push) begin
                    r_rsp_pc <= r_rsp_pc + PC_STEP;
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
            end
            r_outstanding <= w_outstanding_nxt;
            r_discard     <= w_discard_nxt;
            r_count       <= w_count_nxt;
            if (w_spurious) begin
                r_protocol_err <= 1'b1;
            end
        end
    end

    // Queue storage carries no reset; entries are only visible once count says so.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_pc[r_wr_ptr]   <= r_rsp_pc;
            r_q_inst[r_wr_ptr] <= mem_rdata_i;
        end
    end

endmodule

// File: tb/tb_inst_prefetch_unit.sv
// Scoreboard bench for inst_prefetch_unit: bench acts as memory, expected {pc, inst} queued at grant.
module tb_inst_prefetch_unit;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk;
    logic        resetn;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_pc_o;
    logic [31:0] out_inst_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        protocol_err_o;

    inst_prefetch_unit #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk), .resetn(resetn),
        .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_pc_o(out_pc_o), .out_inst_o(out_inst_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .protocol_err_o(protocol_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; } mem_t;
    typedef struct packed { logic [31:0] pc; logic [31:0] inst; } exp_t;

    mem_t        pend_q[$];
    exp_t        exp_q[$];
    logic [31:0] exp_pc;
    logic [31:0] first_gnt;
    int          cyc, lat, n_gnt, n_pop;
    int          n_checks, n_pass;
    logic        spur;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic clr();
        n_gnt = 0;
        n_pop = 0;
        first_gnt = '0;
    endtask

    // One cycle: drive memory response, settle, score handshakes, advance to next negedge.
    task automatic tick();
        mem_t m;
        exp_t e;
        if (spur) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = 32'hDEAD_BEEF;
        end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            m = pend_q.pop_front();
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = memf(m.addr);
        end else begin
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = '0;
        end
        #1;
        if (redirect_valid_i) begin
            check_eq("redir_req", mem_req_o, 0);
            check_eq("redir_vld", out_valid_o, 0);
        end
        if (exp_q.size() == 0) begin
            check_eq("idle_vld", out_valid_o, 0);
        end else if (out_valid_o && out_ready_i) begin
            e = exp_q.pop_front();
            check_eq("out_pc", out_pc_o, e.pc);
            check_eq("out_inst", out_inst_o, e.inst);
            n_pop++;
        end
        if (mem_req_o && mem_gnt_i) begin
            check_eq("req_addr", mem_addr_o, exp_pc);
            if (n_gnt == 0) first_gnt = mem_addr_o;
            m.addr = mem_addr_o;
            m.due  = cyc + lat;
            pend_q.push_back(m);
            e.pc   = exp_pc;
            e.inst = memf(exp_pc);
            exp_q.push_back(e);
            exp_pc = exp_pc + 32'd4;
            n_gnt++;
        end
        if (redirect_valid_i) begin
            exp_q.delete();
            exp_pc = redirect_pc_i;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic tick_redirect(input logic [31:0] target);
        redirect_valid_i = 1'b1;
        redirect_pc_i    = target;
        tick();
        redirect_valid_i = 1'b0;
    endtask

    task automatic drain(input string tag);
        mem_gnt_i   = 1'b0;
        out_ready_i = 1'b1;
        for (int i = 0; i < 60 && (exp_q.size() != 0 || pend_q.size() != 0); i++) tick();
        check_eq(tag, exp_q.size(), 0);
    endtask

    task automatic clear_model();
        pend_q.delete();
        exp_q.delete();
        exp_pc           = RESET_PC;
        redirect_valid_i = 1'b0;
        redirect_pc_i    = '0;
        mem_gnt_i        = 1'b0;
        out_ready_i      = 1'b0;
        mem_rvalid_i     = 1'b0;
        mem_rdata_i      = '0;
        spur             = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        cyc      = 0;
        lat      = 1;
        resetn   = 1'b0;
        clear_model();
        clr();

        // Reset values, then first cycle after release.
        @(negedge clk);
        #1;
        check_eq("rst_vld", out_valid_o, 0);
        check_eq("rst_req", mem_req_o, 0);
        check_eq("rst_err", protocol_err_o, 0);
        check_eq("rst_addr", mem_addr_o, RESET_PC);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check_eq("rel_req", mem_req_o, 1);
        check_eq("rel_addr", mem_addr_o, RESET_PC);

        // Full-throughput stream.
        mem_gnt_i = 1'b1; out_ready_i = 1'b1; lat = 1;
        clr();
        repeat (20) tick();
        check_eq("stream_gnts", n_gnt, 20);
        check_eq("stream_pops", n_pop, 18);
        drain("drain_stream");

        // Backpressure fills exactly DEPTH entries, then resumes at +0x10.
        do_reset();
        mem_gnt_i = 1'b1; out_ready_i = 1'b0; lat = 1;
        clr();
        repeat (12) tick();
        check_eq("full_gnts", n_gnt, 4);
        #1;
        check_eq("full_req", mem_req_o, 0);
        check_eq("full_vld", out_valid_o, 1);
        out_ready_i = 1'b1;
        clr();
        repeat (8) tick();
        check_eq("resume_addr", first_gnt, 32'h8000_0010);
        drain("drain_full");

        // Redirect with two requests in flight.
        mem_gnt_i = 1'b1; out_ready_i = 1'b1; lat = 3;
        repeat (2) tick();
        #1;
        check_eq("maxout_req", mem_req_o, 0);
        tick_redirect(32'h0000_0100);
        clr();
        repeat (14) tick();
        check_eq("redir_first", first_gnt, 32'h0000_0100);
        drain("drain_redir");

        // Redirect coinciding with a response and a would-be pop.
        mem_gnt_i = 1'b1; out_ready_i = 1'b1; lat = 1;
        repeat (4) tick();
        #1;
        check_eq("pre_redir_vld", out_valid_o, 1);
        tick_redirect(32'h0000_0400);
        #1;
        check_eq("post_redir_vld", out_valid_o, 0);
        check_eq("post_redir_req", mem_req_o, 1);
        check_eq("post_redir_addr", mem_addr_o, 32'h0000_0400);
        repeat (6) tick();
        drain("drain_redir_rsp");

        // Back-to-back redirects with stale responses pending.
        mem_gnt_i = 1'b1; out_ready_i = 1'b1; lat = 3;
        repeat (2) tick();
        tick_redirect(32'h0000_0200);
        tick_redirect(32'h0000_0300);
        clr();
        repeat (12) tick();
        check_eq("b2b_first", first_gnt, 32'h0000_0300);
        drain("drain_b2b");

        // Spurious response with nothing outstanding.
        mem_gnt_i = 1'b1; out_ready_i = 1'b0; lat = 1;
        repeat (8) tick();
        mem_gnt_i = 1'b0;
        #1;
        check_eq("pre_spur_err", protocol_err_o, 0);
        spur = 1'b1;
        tick();
        spur = 1'b0;
        tick();
        check_eq("spur_err", protocol_err_o, 1);
        check_eq("spur_vld", out_valid_o, 1);
        clr();
        drain("drain_spur");
        check_eq("spur_pops", n_pop, 4);
        repeat (3) tick();
        check_eq("spur_sticky", protocol_err_o, 1);

        // Asynchronous reset in the middle of a burst.
        mem_gnt_i = 1'b1; out_ready_i = 1'b1; lat = 1;
        repeat (5) tick();
        #2;
        resetn = 1'b0;
        mem_rvalid_i = 1'b0;
        #1;
        check_eq("arst_vld", out_valid_o, 0);
        check_eq("arst_req", mem_req_o, 0);
        check_eq("arst_err", protocol_err_o, 0);
        check_eq("arst_addr", mem_addr_o, RESET_PC);
        clear_model();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        mem_gnt_i = 1'b1; out_ready_i = 1'b1; lat = 2;
        clr();
        repeat (10) tick();
        check_eq("arst_first", first_gnt, RESET_PC);
        drain("drain_arst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
